// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes host, CPU data and CPU fetch accesses onto one
// single-port synchronous memory. Define ARB_RR_EN for round-robin D/I arbitration.
module mem_port_arbiter #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          HREQ,
    input  logic          HWE,
    input  logic [AW-1:0] HA,
    input  logic [DW-1:0] HWD,
    output logic          HACK,
    input  logic          DREQ,
    input  logic          DWE,
    input  logic [AW-1:0] DA,
    input  logic [DW-1:0] DWD,
    output logic          DACK,
    input  logic          IREQ,
    input  logic [AW-1:0] IA,
    output logic          IACK,
    output logic [DW-1:0] RDATA,
    output logic [AW-1:0] MA,
    output logic          MWE,
    output logic [DW-1:0] MWD,
    input  logic [DW-1:0] MRD
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] GNT_H = 2'd0;
    localparam logic [1:0] GNT_D = 2'd1;
    localparam logic [1:0] GNT_I = 2'd2;

    state_t        state, state_d;
    logic [1:0]    gnt, gnt_d;
    logic          acc_we, acc_we_d;
    logic [AW-1:0] ma_d;
    logic          mwe_d;
    logic [DW-1:0] mwd_d;
    logic [DW-1:0] rdata_d;
    logic          hack_d, dack_d, iack_d;
    logic          h_vld, d_vld, i_vld;
    logic          win;
    logic [1:0]    win_id;

`ifdef ARB_RR_EN
    // 1: fetch port wins the next D/I tie, 0: data port wins
    logic          rr_i, rr_i_d;
`endif

    // Winner selection; a requester being acked this cycle is masked out
    always_comb begin
        h_vld  = HREQ & ~HACK;
        d_vld  = DREQ & ~DACK;
        i_vld  = IREQ & ~IACK;
        win    = h_vld | d_vld | i_vld;
        win_id = GNT_H;
        if (h_vld) begin
            win_id = GNT_H;
        end else if (d_vld && i_vld) begin
`ifdef ARB_RR_EN
            win_id = rr_i ? GNT_I : GNT_D;
`else
            win_id = GNT_D;
`endif
        end else if (d_vld) begin
            win_id = GNT_D;
        end else if (i_vld) begin
            win_id = GNT_I;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        gnt_d    = gnt;
        acc_we_d = acc_we;
        ma_d     = MA;
        mwe_d    = 1'b0;
        mwd_d    = MWD;
        rdata_d  = RDATA;
        hack_d   = 1'b0;
        dack_d   = 1'b0;
        iack_d   = 1'b0;
`ifdef ARB_RR_EN
        rr_i_d   = rr_i;
`endif
        unique case (state)
            IDLE: begin
                if (win) begin
                    state_d = ACCESS;
                    gnt_d   = win_id;
                    case (win_id)
                        GNT_H: begin
                            ma_d  = HA;
                            mwe_d = HWE;
                            mwd_d = HWD;
                        end
                        GNT_D: begin
                            ma_d  = DA;
                            mwe_d = DWE;
                            mwd_d = DWD;
                        end
                        default: begin
                            ma_d  = IA;
                            mwe_d = 1'b0;
                        end
                    endcase
                    acc_we_d = mwe_d;
`ifdef ARB_RR_EN
                    if (win_id != GNT_H) begin
                        rr_i_d = (win_id == GNT_D);
                    end
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (!acc_we) begin
                    rdata_d = MRD;
                end
                hack_d = (gnt == GNT_H);
                dack_d = (gnt == GNT_D);
                iack_d = (gnt == GNT_I);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CK) begin
        if (RST) begin
            state  <= IDLE;
            gnt    <= GNT_H;
            acc_we <= 1'b0;
            MA     <= '0;
            MWE    <= 1'b0;
            MWD    <= '0;
            RDATA  <= '0;
            HACK   <= 1'b0;
            DACK   <= 1'b0;
            IACK   <= 1'b0;
`ifdef ARB_RR_EN
            rr_i   <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            gnt    <= gnt_d;
            acc_we <= acc_we_d;
            MA     <= ma_d;
            MWE    <= mwe_d;
            MWD    <= mwd_d;
            RDATA  <= rdata_d;
            HACK   <= hack_d;
            DACK   <= dack_d;
            IACK   <= iack_d;
`ifdef ARB_RR_EN
            rr_i   <= rr_i_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed test-plan steps followed by random
// traffic, all checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          CK = 1'b0;
    logic          RST;
    logic          HREQ, HWE, DREQ, DWE, IREQ;
    logic [15:0]   HA, HWD, DA, DWD, IA;
    logic          HACK, DACK, IACK, MWE;
    logic [15:0]   RDATA, MA, MWD, MRD;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .CK(CK), .RST(RST),
        .HREQ(HREQ), .HWE(HWE), .HA(HA), .HWD(HWD), .HACK(HACK),
        .DREQ(DREQ), .DWE(DWE), .DA(DA), .DWD(DWD), .DACK(DACK),
        .IREQ(IREQ), .IA(IA), .IACK(IACK),
        .RDATA(RDATA), .MA(MA), .MWE(MWE), .MWD(MWD), .MRD(MRD)
    );

    always #5 CK = ~CK;

    // Single-port synchronous memory with one-cycle registered read
    logic [15:0] mem [0:65535];
    always @(posedge CK) begin
        if (MWE) mem[MA] <= MWD;
        MRD <= mem[MA];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    // Reference model: one transaction in flight, acked three cycles after its grant
    logic [15:0] ref_mem [0:65535];
    bit          mon_en = 1'b0;
    int          cyc = 0;
    bit          busy = 1'b0;
    int          g_cyc = 0;
    int          g_id = 0;
    logic        g_we = 1'b0;
    logic [15:0] g_addr = 16'h0;
    logic [15:0] g_data = 16'h0;
    logic [15:0] exp_rdata = 16'h0;
    int          exp_ack_id;
    int          w;
    bit          hv, dv, iv;
`ifdef ARB_RR_EN
    bit          rr_i = 1'b0;
`endif

    always @(negedge CK) begin
        if (mon_en) begin
            cyc++;
            exp_ack_id = (busy && cyc == g_cyc + 3) ? g_id : -1;
            if (exp_ack_id >= 0 && !g_we) exp_rdata = ref_mem[g_addr];
            chk("m_hack", 16'(HACK), 16'(exp_ack_id == 0));
            chk("m_dack", 16'(DACK), 16'(exp_ack_id == 1));
            chk("m_iack", 16'(IACK), 16'(exp_ack_id == 2));
            chk("m_rdata", RDATA, exp_rdata);
            chk("m_mwe", 16'(MWE), 16'(busy && cyc == g_cyc + 1 && g_we));
            if (busy && cyc == g_cyc + 1) begin
                chk("m_ma", MA, g_addr);
                if (g_we) chk("m_mwd", MWD, g_data);
            end
            if (exp_ack_id >= 0) begin
                if (g_we) ref_mem[g_addr] = g_data;
                busy = 1'b0;
            end
            if (RST) begin
                if (busy && cyc == g_cyc + 1 && g_we) ref_mem[g_addr] = g_data;
                busy      = 1'b0;
                exp_rdata = 16'h0;
`ifdef ARB_RR_EN
                rr_i      = 1'b0;
`endif
            end else if (!busy) begin
                hv = HREQ && exp_ack_id != 0;
                dv = DREQ && exp_ack_id != 1;
                iv = IREQ && exp_ack_id != 2;
                w  = -1;
                if (hv) w = 0;
                else if (dv && iv) begin
`ifdef ARB_RR_EN
                    w = rr_i ? 2 : 1;
`else
                    w = 1;
`endif
                end
                else if (dv) w = 1;
                else if (iv) w = 2;
                if (w >= 0) begin
                    busy  = 1'b1;
                    g_cyc = cyc;
                    g_id  = w;
                    case (w)
                        0:       begin g_we = HWE;  g_addr = HA; g_data = HWD; end
                        1:       begin g_we = DWE;  g_addr = DA; g_data = DWD; end
                        default: begin g_we = 1'b0; g_addr = IA; g_data = 16'h0; end
                    endcase
`ifdef ARB_RR_EN
                    if (w == 1) rr_i = 1'b1;
                    else if (w == 2) rr_i = 1'b0;
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic new_req(input int r);
        case (r)
            0: begin
                HREQ = 1'b1; HWE = 1'($urandom_range(0, 1));
                HA = 16'h0100 + 16'($urandom_range(0, 15)); HWD = 16'($urandom);
            end
            1: begin
                DREQ = 1'b1; DWE = 1'($urandom_range(0, 1));
                DA = 16'h0100 + 16'($urandom_range(0, 15)); DWD = 16'($urandom);
            end
            default: begin
                IREQ = 1'b1; IA = 16'h0100 + 16'($urandom_range(0, 15));
            end
        endcase
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ma"}, MA, 16'h0);
        chk({tag, "_mwe"}, 16'(MWE), 16'h0);
        chk({tag, "_mwd"}, MWD, 16'h0);
        chk({tag, "_rdata"}, RDATA, 16'h0);
        chk({tag, "_hack"}, 16'(HACK), 16'h0);
        chk({tag, "_dack"}, 16'(DACK), 16'h0);
        chk({tag, "_iack"}, 16'(IACK), 16'h0);
    endtask

    int h_at, d_at, i_at;

    initial begin
        RST = 1'b1;
        HREQ = 1'b0; HWE = 1'b0; HA = 16'h0; HWD = 16'h0;
        DREQ = 1'b0; DWE = 1'b0; DA = 16'h0; DWD = 16'h0;
        IREQ = 1'b0; IA = 16'h0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     <= 16'h0;
            ref_mem[i]  = 16'h0;
        end
        mem[16'h0005]     <= 16'hC1A5;
        ref_mem[16'h0005]  = 16'hC1A5;
        step();
        step();
        chk_reset_outputs("reset");
        RST    = 1'b0;
        mon_en = 1'b1;

        // single fetch, then ACK masking keeps the FSM idle
        IREQ = 1'b1; IA = 16'h0005;
        step();
        chk("fetch_ma", MA, 16'h0005);
        chk("fetch_mwe", 16'(MWE), 16'h0);
        step();
        chk("fetch_iack_early", 16'(IACK), 16'h0);
        step();
        chk("fetch_iack", 16'(IACK), 16'h1);
        chk("fetch_rdata", RDATA, 16'hC1A5);
        chk("fetch_dack", 16'(DACK), 16'h0);
        chk("fetch_hack", 16'(HACK), 16'h0);
        IREQ = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mask_iack", 16'(IACK), 16'h0);
            chk("mask_mwe", 16'(MWE), 16'h0);
        end

        // store then load
        DREQ = 1'b1; DWE = 1'b1; DA = 16'h0040; DWD = 16'hBEEF;
        step();
        chk("store_mwe", 16'(MWE), 16'h1);
        chk("store_ma", MA, 16'h0040);
        chk("store_mwd", MWD, 16'hBEEF);
        step();
        chk("store_mwe_off", 16'(MWE), 16'h0);
        step();
        chk("store_dack", 16'(DACK), 16'h1);
        chk("store_rdata_held", RDATA, 16'hC1A5);
        DREQ = 1'b0; DWE = 1'b0;
        step();
        DREQ = 1'b1;
        step(); step(); step();
        chk("load_dack", 16'(DACK), 16'h1);
        chk("load_rdata", RDATA, 16'hBEEF);
        DREQ = 1'b0;
        step();

        // simultaneous D/I from idle right after a D grant
        DREQ = 1'b1; DA = 16'h0040; IREQ = 1'b1; IA = 16'h0005;
        d_at = -1; i_at = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (DACK && d_at < 0) begin d_at = k; DREQ = 1'b0; end
            if (IACK && i_at < 0) begin i_at = k; IREQ = 1'b0; end
        end
`ifdef ARB_RR_EN
        chk("ptr_iack_cycle", 16'(i_at), 16'd3);
        chk("ptr_dack_cycle", 16'(d_at), 16'd6);
`else
        chk("ptr_dack_cycle", 16'(d_at), 16'd3);
        chk("ptr_iack_cycle", 16'(i_at), 16'd6);
`endif

        // lone fetch so the D/I tie goes to D next
        IREQ = 1'b1; IA = 16'h0005;
        step(); step(); step();
        chk("solo_iack", 16'(IACK), 16'h1);
        IREQ = 1'b0;
        step();

        // three-way contention, each requester drops on its ACK
        HREQ = 1'b1; HWE = 1'b0; HA = 16'h0040;
        DREQ = 1'b1; DWE = 1'b0; DA = 16'h0005;
        IREQ = 1'b1; IA = 16'h0040;
        h_at = -1; d_at = -1; i_at = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (HACK && h_at < 0) begin h_at = k; HREQ = 1'b0; end
            if (DACK && d_at < 0) begin d_at = k; DREQ = 1'b0; end
            if (IACK && i_at < 0) begin i_at = k; IREQ = 1'b0; end
        end
        chk("three_hack_cycle", 16'(h_at), 16'd3);
        chk("three_dack_cycle", 16'(d_at), 16'd6);
        chk("three_iack_cycle", 16'(i_at), 16'd9);

        // D and I held continuously: the ACK mask alternates the grants
        DREQ = 1'b1; DWE = 1'b0; DA = 16'h0040; IREQ = 1'b1; IA = 16'h0005;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k % 3 == 0) begin
                chk("fair_dack", 16'(DACK), 16'((k / 3) % 2 == 1));
                chk("fair_iack", 16'(IACK), 16'((k / 3) % 2 == 0));
            end else begin
                chk("fair_idle_acks", 16'({DACK, IACK}), 16'h0);
            end
        end
        DREQ = 1'b0; IREQ = 1'b0;
        step();

        // reset in the ACCESS cycle of a write
        DREQ = 1'b1; DWE = 1'b1; DA = 16'h0010; DWD = 16'h1234;
        step();
        chk("rstacc_mwe", 16'(MWE), 16'h1);
        RST = 1'b1;
        step();
        RST = 1'b0; DREQ = 1'b0; DWE = 1'b0;
        chk_reset_outputs("rstacc");
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rstacc_no_dack", 16'(DACK), 16'h0);
        end
        chk("rstacc_mem", mem[16'h0010], 16'h1234);
        DREQ = 1'b1;
        step(); step(); step();
        chk("rstacc_load", RDATA, 16'h1234);
        DREQ = 1'b0;
        step();

        // random traffic with occasional resets
        for (int n = 0; n < 800; n++) begin
            step();
            RST = ($urandom_range(0, 149) == 0);
            if (HACK) begin HREQ = 1'b0; if ($urandom_range(0, 1) == 1) new_req(0); end
            else if (!HREQ && $urandom_range(0, 3) == 0) new_req(0);
            if (DACK) begin DREQ = 1'b0; if ($urandom_range(0, 1) == 1) new_req(1); end
            else if (!DREQ && $urandom_range(0, 3) == 0) new_req(1);
            if (IACK) begin IREQ = 1'b0; if ($urandom_range(0, 1) == 1) new_req(2); end
            else if (!IREQ && $urandom_range(0, 3) == 0) new_req(2);
        end
        RST = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (HACK) HREQ = 1'b0;
            if (DACK) DREQ = 1'b0;
            if (IACK) IREQ = 1'b0;
        end
        chk("drain_done", 16'({HREQ, DREQ, IREQ}), 16'h0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
